divisor_signo: RTL and testbench
================================

// Module: divisor_signo
// PURPOSE
//  Sequential signed divider, the inverse of the Booth signed multiplier: splits a 16-bit
//   signed product back into quotient and remainder for a given 8-bit signed operand.
//  Sits beside the multiplier under top; same start/done style, results go to LED/7-seg mux.
//  Restoring shift-subtract on magnitudes, one quotient bit per clock, sign fix at the end.
//  Truncates toward zero; remainder takes the sign of the dividend.
// PARAMETERS
//  N_DVD  16  dividend / quotient width (signed, two's complement)
//  N_DVS  8   divisor / remainder width (signed, two's complement)
// PORTS
//  CLK100MHZ  in   1      system clock, all state on rising edge
//  reset      in   1      asynchronous, active-low; 0 forces IDLE and clears all outputs
//  inicio     in   1      start request, sampled only in IDLE
//  dividendo  in   N_DVD  signed dividend, captured on accepted inicio
//  divisor    in   N_DVS  signed divisor, captured on accepted inicio
//  cociente   out  N_DVD  signed quotient, held until next completion
//  residuo    out  N_DVS  signed remainder, held until next completion
//  ocupado    out  1      high while a division is in progress
//  listo      out  1      one-cycle pulse: cociente/residuo/flags just updated
//  div_cero   out  1      last division had divisor == 0 (held with results)
//  desborde   out  1      last division overflowed (-2^(N_DVD-1) / -1), held with results
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; cociente=0, residuo=0, ocupado=0, listo=0,
//   div_cero=0, desborde=0; iteration counter=0. Reset mid-division aborts, no listo.
//  States: IDLE -> ITER -> FIX -> IDLE; IDLE -> ZERO -> IDLE for divisor==0.
//  IDLE: edge k with inicio=1: capture |dividendo| (N_DVD bits unsigned), |divisor|
//   (N_DVS bits unsigned), both sign bits; clear partial remainder (N_DVS+1 bits);
//   counter=N_DVD-1; ocupado=1; go ITER (or ZERO if divisor==0).
//  ITER: each edge shift {rem,dvd} left 1; if rem>=|divisor| subtract and set quotient
//   LSB=1 else 0; counter--; after N_DVD edges (counter was 0) go FIX.
//  FIX: cociente = sign(dvd)^sign(dvs) ? -q : q; residuo = sign(dvd) ? -r : r;
//   desborde=1 iff dividendo=-2^(N_DVD-1) and divisor=-1 (cociente=16'h8000, residuo=0);
//   div_cero=0; listo=1, ocupado=0 for the cycle after this edge; go IDLE.
//  ZERO: cociente=0, residuo=0, div_cero=1, desborde=0, listo=1, ocupado=0; go IDLE.
//  Latency: inicio accepted at edge k -> listo high after edge k+N_DVD+1 (17 clocks);
//   divide-by-zero -> listo high after edge k+1.
//  listo is high exactly one cycle; inicio in that same cycle is accepted (back-to-back).
//  inicio while ocupado=1 is ignored; operand changes after capture have no effect.
//  Outputs change only on the listo edge; never glitch mid-division.
//  Widths: |divisor|<=128 so |residuo|<=127 always fits N_DVS signed; magnitude of
//   -32768 is 32768 and fits N_DVD unsigned; only the -1 case can overflow.
// TESTING
//  28 / 7 -> cociente=4, residuo=0, listo exactly 17 clocks after inicio, ocupado 17 clks.
//  -100 / 7 -> cociente=-14 (16'hFFF2), residuo=-2 (8'hFE); 1000 / -3 -> -333, 1.
//  Round trip: A=4,B=7 via multiplier -> product 28; 28 / 4 -> 7 r0; -32768 / -128 -> 256 r0.
//  500 / 0 -> div_cero=1, cociente=0, residuo=0, listo 1 clock after inicio.
//  -32768 / -1 -> desborde=1, cociente=16'h8000, residuo=0; next 10/3 clears flag -> 3, 1.
//  inicio pulsed mid-division ignored; reset=0 at iteration 8 -> all outputs 0, no listo,
//   new inicio after release completes normally in 17 clocks.

Source files
------------

// File: rtl/divisor_signo_if.sv
// Start/done bus between the signed divider and whoever drives it.
interface divisor_signo_if #(
   parameter int unsigned N_DVD = 16,
   parameter int unsigned N_DVS = 8
);
   logic             inicio;
   logic [N_DVD-1:0] dividendo;
   logic [N_DVS-1:0] divisor;
   logic [N_DVD-1:0] cociente;
   logic [N_DVS-1:0] residuo;
   logic             ocupado;
   logic             listo;
   logic             div_cero;
   logic             desborde;

   modport master (
      output inicio, dividendo, divisor,
      input  cociente, residuo, ocupado, listo, div_cero, desborde
   );

   modport slave (
      input  inicio, dividendo, divisor,
      output cociente, residuo, ocupado, listo, div_cero, desborde
   );
endinterface

// File: rtl/divisor_signo.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one quotient bit
// per clock, sign correction in a final step. Truncates toward zero; the remainder
// carries the sign of the dividend.
module divisor_signo #(
   parameter int unsigned N_DVD = 16,
   parameter int unsigned N_DVS = 8
) (
   input logic             CLK100MHZ,
   input logic             reset,
   divisor_signo_if.slave  bus
);
   localparam int unsigned CW = $clog2(N_DVD);

   typedef enum logic [1:0] {StIdle, StIter, StFix, StZero} state_e;

   state_e           state_q, state_d;
   logic [N_DVS:0]   rem_q, rem_d;      // partial remainder, one guard bit
   logic [N_DVD-1:0] dvd_q, dvd_d;      // dividend magnitude, becomes the quotient
   logic [N_DVS-1:0] dvs_q, dvs_d;      // divisor magnitude
   logic             sd_q, sd_d;        // dividend sign
   logic             sv_q, sv_d;        // divisor sign
   logic             ovf_q, ovf_d;      // operands were MIN / -1
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_DVD-1:0] coc_q, coc_d;
   logic [N_DVS-1:0] res_q, res_d;
   logic             ocu_q, ocu_d;
   logic             listo_q, listo_d;
   logic             dz_q, dz_d;
   logic             des_q, des_d;
   logic [N_DVS:0]   rem_sh;

   // Next-state and datapath: capture, iterate, fix signs, publish results.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      sd_d    = sd_q;
      sv_d    = sv_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      coc_d   = coc_q;
      res_d   = res_q;
      ocu_d   = ocu_q;
      listo_d = 1'b0;
      dz_d    = dz_q;
      des_d   = des_q;
      // The remainder never exceeds N_DVS bits before the shift, so dropping its MSB is safe.
      rem_sh  = (N_DVS + 1)'({rem_q, dvd_q[N_DVD-1]});

      unique case (state_q)
         StIdle: begin
            if (bus.inicio) begin
               sd_d  = bus.dividendo[N_DVD-1];
               sv_d  = bus.divisor[N_DVS-1];
               dvd_d = bus.dividendo[N_DVD-1] ? -bus.dividendo : bus.dividendo;
               dvs_d = bus.divisor[N_DVS-1] ? -bus.divisor : bus.divisor;
               ovf_d = (bus.dividendo == {1'b1, {(N_DVD-1){1'b0}}}) && (bus.divisor == '1);
               rem_d = '0;
               cnt_d = CW'(N_DVD - 1);
               ocu_d = 1'b1;
               state_d = (bus.divisor == '0) ? StZero : StIter;
            end
         end
         StIter: begin
            if (rem_sh >= {1'b0, dvs_q}) begin
               rem_d = rem_sh - {1'b0, dvs_q};
               dvd_d = {dvd_q[N_DVD-2:0], 1'b1};
            end else begin
               rem_d = rem_sh;
               dvd_d = {dvd_q[N_DVD-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = StFix;
         end
         StFix: begin
            // MIN / -1 yields magnitude 2^(N_DVD-1), which reads back as MIN unchanged.
            coc_d   = (sd_q ^ sv_q) ? -dvd_q : dvd_q;
            res_d   = sd_q ? -rem_q[N_DVS-1:0] : rem_q[N_DVS-1:0];
            des_d   = ovf_q;
            dz_d    = 1'b0;
            listo_d = 1'b1;
            ocu_d   = 1'b0;
            state_d = StIdle;
         end
         StZero: begin
            coc_d   = '0;
            res_d   = '0;
            dz_d    = 1'b1;
            des_d   = 1'b0;
            listo_d = 1'b1;
            ocu_d   = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and result registers; reset aborts any division in flight.
   always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         sd_q    <= 1'b0;
         sv_q    <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         coc_q   <= '0;
         res_q   <= '0;
         ocu_q   <= 1'b0;
         listo_q <= 1'b0;
         dz_q    <= 1'b0;
         des_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         sd_q    <= sd_d;
         sv_q    <= sv_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         coc_q   <= coc_d;
         res_q   <= res_d;
         ocu_q   <= ocu_d;
         listo_q <= listo_d;
         dz_q    <= dz_d;
         des_q   <= des_d;
      end
   end

   assign bus.cociente = coc_q;
   assign bus.residuo  = res_q;
   assign bus.ocupado  = ocu_q;
   assign bus.listo    = listo_q;
   assign bus.div_cero = dz_q;
   assign bus.desborde = des_q;
endmodule

// File: tb/tb_divisor_signo.sv
// Scoreboard bench for divisor_signo: the driver queues expected results, a monitor
// checks them whenever listo is seen.
module tb_divisor_signo;
   logic CLK100MHZ = 1'b0;
   logic reset     = 1'b0;
   int   cyc       = 0;
   int   n_cmp     = 0;
   int   n_err     = 0;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
      logic        des;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];

   divisor_signo_if #(.N_DVD(16), .N_DVS(8)) bus ();

   divisor_signo #(.N_DVD(16), .N_DVS(8)) dut (
      .CLK100MHZ (CLK100MHZ),
      .reset     (reset),
      .bus       (bus)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;
   always @(posedge CLK100MHZ) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every listo must match the oldest queued expectation.
   always @(negedge CLK100MHZ) begin
      if (reset && bus.listo) begin
         if (sb.size() == 0) begin
            chk("unexpected_listo", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_cociente"}, 32'(bus.cociente), 32'(e.q));
            chk({e.name, "_residuo"}, 32'(bus.residuo), 32'(e.r));
            chk({e.name, "_div_cero"}, 32'(bus.div_cero), 32'(e.dz));
            chk({e.name, "_desborde"}, 32'(bus.desborde), 32'(e.des));
            chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
            chk({e.name, "_ocupado_low"}, 32'(bus.ocupado), 32'd0);
         end
      end
   end

   // Call right after a falling edge; returns after the accepting rising edge.
   task automatic issue(input string name, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er,
                        input logic dz, input logic des, input int lat);
      exp_t e;
      bus.inicio    = 1'b1;
      bus.dividendo = a;
      bus.divisor   = b;
      e.q = eq; e.r = er; e.dz = dz; e.des = des; e.due = cyc + 1 + lat; e.name = name;
      sb.push_back(e);
      @(negedge CLK100MHZ);
      bus.inicio = 1'b0;
   endtask

   // Waits (bounded) for listo; reports how many sampled cycles ocupado was high.
   task automatic wait_listo(output int busy);
      busy = bus.ocupado ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK100MHZ);
         if (bus.listo) return;
         if (bus.ocupado) busy++;
      end
      chk("listo_timeout", 32'd1, 32'd0);
      sb.delete();
   endtask

   initial begin
      int busy;
      bus.inicio    = 1'b0;
      bus.dividendo = '0;
      bus.divisor   = '0;
      repeat (3) @(negedge CLK100MHZ);
      chk("rst_cociente", 32'(bus.cociente), 32'd0);
      chk("rst_residuo", 32'(bus.residuo), 32'd0);
      chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
      chk("rst_listo", 32'(bus.listo), 32'd0);
      chk("rst_flags", 32'({bus.div_cero, bus.desborde}), 32'd0);
      reset = 1'b1;
      @(negedge CLK100MHZ);

      issue("d28_7", 16'd28, 8'd7, 16'd4, 8'd0, 1'b0, 1'b0, 17);
      wait_listo(busy);
      chk("d28_7_ocupado_cycles", 32'(busy), 32'd17);

      issue("m100_7", -16'sd100, 8'd7, 16'hFFF2, 8'hFE, 1'b0, 1'b0, 17);
      wait_listo(busy);
      issue("d1000_m3", 16'd1000, -8'sd3, 16'hFEB3, 8'd1, 1'b0, 1'b0, 17);
      wait_listo(busy);
      issue("d28_4", 16'd28, 8'd4, 16'd7, 8'd0, 1'b0, 1'b0, 17);
      wait_listo(busy);
      issue("min_m128", 16'h8000, 8'h80, 16'd256, 8'd0, 1'b0, 1'b0, 17);
      wait_listo(busy);
      issue("m7_2", -16'sd7, 8'd2, 16'hFFFD, 8'hFF, 1'b0, 1'b0, 17);
      wait_listo(busy);
      issue("d127_m128", 16'd127, 8'h80, 16'd0, 8'h7F, 1'b0, 1'b0, 17);
      wait_listo(busy);

      issue("d500_0", 16'd500, 8'd0, 16'd0, 8'd0, 1'b1, 1'b0, 1);
      wait_listo(busy);

      // Overflow, then a back-to-back start issued during the listo cycle.
      issue("min_m1", 16'h8000, 8'hFF, 16'h8000, 8'd0, 1'b0, 1'b1, 17);
      wait_listo(busy);
      issue("d10_3", 16'd10, 8'd3, 16'd3, 8'd1, 1'b0, 1'b0, 17);
      wait_listo(busy);

      // Start ignored while busy; operand changes after capture do nothing.
      issue("ign", 16'd28, 8'd4, 16'd7, 8'd0, 1'b0, 1'b0, 17);
      repeat (5) @(negedge CLK100MHZ);
      bus.inicio = 1'b1; bus.dividendo = 16'd99; bus.divisor = 8'd9;
      @(negedge CLK100MHZ);
      bus.inicio = 1'b0;
      wait_listo(busy);
      repeat (20) @(negedge CLK100MHZ);

      // Asynchronous reset mid-division aborts without listo.
      issue("abort", 16'd1000, -8'sd3, 16'hFEB3, 8'd1, 1'b0, 1'b0, 17);
      repeat (8) @(negedge CLK100MHZ);
      #2 reset = 1'b0;
      sb.delete();
      #1;
      chk("abort_cociente", 32'(bus.cociente), 32'd0);
      chk("abort_residuo", 32'(bus.residuo), 32'd0);
      chk("abort_ocupado", 32'(bus.ocupado), 32'd0);
      chk("abort_listo", 32'(bus.listo), 32'd0);
      @(negedge CLK100MHZ);
      reset = 1'b1;
      repeat (20) @(negedge CLK100MHZ);
      issue("after_rst", -16'sd100, 8'd7, 16'hFFF2, 8'hFE, 1'b0, 1'b0, 17);
      wait_listo(busy);
      chk("after_rst_ocupado_cycles", 32'(busy), 32'd17);

      repeat (5) @(negedge CLK100MHZ);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
